// File: rtl/me_unit_varlat.sv
// Memory-access pipeline stage between EX and WB for a variable-latency data memory.
// Holds a load/store until its in-order response returns, buffers it under WB stall, drops stale ones.
module me_unit_varlat #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned DEST_W = 5,
  parameter int unsigned DROP_W = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              ex_valid,
  input  logic [PC_W-1:0]   ex_pc,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              ex_res_from_mem,
  input  logic              ex_gr_we,
  input  logic [DEST_W-1:0] ex_dest,
  input  logic [1:0]        ex_ld_size,
  input  logic              ex_ld_unsigned,
  input  logic              ex_req_sent,
  output logic              me_allow_in,
  input  logic              data_ok,
  input  logic [DATA_W-1:0] rdata,
  input  logic              wb_allow_in,
  input  logic              flush,
  output logic              wb_valid,
  output logic [PC_W-1:0]   wb_pc,
  output logic              wb_gr_we,
  output logic [DEST_W-1:0] wb_dest,
  output logic [DATA_W-1:0] wb_result,
  output logic [DEST_W-1:0] me_dest,
  output logic [DATA_W-1:0] me_fwd_res,
  output logic              me_fwd_busy
);

  localparam int unsigned       OffW    = $clog2(DATA_W / 8);
  localparam logic [DROP_W-1:0] DropMax = '1;

  logic              me_valid_q, me_valid_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              res_from_mem_q, res_from_mem_d;
  logic              gr_we_q, gr_we_d;
  logic [DEST_W-1:0] dest_q, dest_d;
  logic [1:0]        ld_size_q, ld_size_d;
  logic              ld_unsigned_q, ld_unsigned_d;
  logic              req_pend_q, req_pend_d;
  logic              buf_valid_q, buf_valid_d;
  logic [DATA_W-1:0] rdata_buf_q, rdata_buf_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

  logic drop_hit, resp_live, owned, ready_go, leave, drop_inc;

  // A response is stale while drop_cnt is non-zero; only a live one can complete ME.
  assign drop_hit  = data_ok & (drop_cnt_q != '0);
  assign resp_live = data_ok & (drop_cnt_q == '0);
  assign owned     = resp_live & me_valid_q & req_pend_q & ~buf_valid_q;
  assign ready_go  = ~req_pend_q | buf_valid_q | resp_live;
  assign leave     = wb_valid & wb_allow_in;
  assign drop_inc  = flush & me_valid_q & req_pend_q & ~buf_valid_q & ~owned;

  assign wb_valid    = me_valid_q & ready_go & ~flush;
  assign me_allow_in = ~me_valid_q | (ready_go & wb_allow_in);

  always_comb begin
    me_valid_d     = me_valid_q;
    pc_d           = pc_q;
    result_d       = result_q;
    res_from_mem_d = res_from_mem_q;
    gr_we_d        = gr_we_q;
    dest_d         = dest_q;
    ld_size_d      = ld_size_q;
    ld_unsigned_d  = ld_unsigned_q;
    req_pend_d     = req_pend_q;
    if (me_allow_in) begin
      me_valid_d = ex_valid;
      if (ex_valid) begin
        pc_d           = ex_pc;
        result_d       = ex_result;
        res_from_mem_d = ex_res_from_mem;
        gr_we_d        = ex_gr_we;
        dest_d         = ex_dest;
        ld_size_d      = ex_ld_size;
        ld_unsigned_d  = ex_ld_unsigned;
        req_pend_d     = ex_req_sent;
      end
    end
    if (flush) begin
      me_valid_d = 1'b0;
    end
  end

  always_comb begin
    buf_valid_d = buf_valid_q;
    rdata_buf_d = rdata_buf_q;
    if (flush || leave) begin
      buf_valid_d = 1'b0;
    end else if (owned && !wb_allow_in) begin
      buf_valid_d = 1'b1;
      rdata_buf_d = rdata;
    end
  end

  // A stale response and a new flush-orphaned request in the same cycle cancel out.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_inc && !drop_hit && drop_cnt_q != DropMax) begin
      drop_cnt_d = drop_cnt_q + DROP_W'(1);
    end else if (drop_hit && !drop_inc) begin
      drop_cnt_d = drop_cnt_q - DROP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      me_valid_q     <= 1'b0;
      pc_q           <= '0;
      result_q       <= '0;
      res_from_mem_q <= 1'b0;
      gr_we_q        <= 1'b0;
      dest_q         <= '0;
      ld_size_q      <= '0;
      ld_unsigned_q  <= 1'b0;
      req_pend_q     <= 1'b0;
      buf_valid_q    <= 1'b0;
      rdata_buf_q    <= '0;
      drop_cnt_q     <= '0;
    end else begin
      me_valid_q     <= me_valid_d;
      pc_q           <= pc_d;
      result_q       <= result_d;
      res_from_mem_q <= res_from_mem_d;
      gr_we_q        <= gr_we_d;
      dest_q         <= dest_d;
      ld_size_q      <= ld_size_d;
      ld_unsigned_q  <= ld_unsigned_d;
      req_pend_q     <= req_pend_d;
      buf_valid_q    <= buf_valid_d;
      rdata_buf_q    <= rdata_buf_d;
      drop_cnt_q     <= drop_cnt_d;
    end
  end

  // Load lane extraction: shift the addressed, size-aligned lane down, then mask and extend.
  logic [DATA_W-1:0] sel_data, shifted, keep, ld_ext;
  logic [OffW-1:0]   off, off_al;
  logic [1:0]        eff_size;
  logic              sign;

  always_comb begin
    sel_data = buf_valid_q ? rdata_buf_q : rdata;
    eff_size = (DATA_W == 32 && ld_size_q == 2'd3) ? 2'd2 : ld_size_q;
    off      = result_q[OffW-1:0];
    case (eff_size)
      2'd0: begin
        off_al = off;
        keep   = DATA_W'(8'hff);
      end
      2'd1: begin
        off_al = off & ~OffW'(1);
        keep   = DATA_W'(16'hffff);
      end
      2'd2: begin
        off_al = off & ~OffW'(3);
        keep   = DATA_W'(32'hffff_ffff);
      end
      default: begin
        off_al = '0;
        keep   = '1;
      end
    endcase
    shifted = sel_data >> {off_al, 3'b000};
    // Sign bit is the top bit of the kept lane.
    sign    = ~ld_unsigned_q & (|(shifted & keep & ~(keep >> 1)));
    ld_ext  = (shifted & keep) | (sign ? ~keep : '0);
  end

  assign wb_pc       = pc_q;
  assign wb_gr_we    = gr_we_q;
  assign wb_dest     = dest_q;
  assign wb_result   = res_from_mem_q ? ld_ext : result_q;
  assign me_fwd_res  = wb_result & {DATA_W{gr_we_q}};
  assign me_dest     = (me_valid_q & gr_we_q) ? dest_q : '0;
  assign me_fwd_busy = me_valid_q & res_from_mem_q & ~ready_go;

  // Upstream must never orphan more responses than the drop counter can track.
  assert property (@(posedge clk) disable iff (!resetn)
                   (drop_inc && !drop_hit) |-> (drop_cnt_q != DropMax));

endmodule

// File: tb/tb_me_unit_varlat.sv
// Bench for me_unit_varlat: transaction-level model of the ME slot and the in-order memory
// response stream, checked every cycle on a 32-bit and a 64-bit instance.
module tb_me_unit_varlat;

  typedef struct packed {
    logic [31:0] pc;
    logic [63:0] res;
    logic        mem;
    logic        we;
    logic [4:0]  dest;
    logic [1:0]  size;
    logic        uns;
    logic        req;
  } ins_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn, ex_valid, ex_res_from_mem, ex_gr_we, ex_ld_unsigned, ex_req_sent;
  logic [31:0] ex_pc;
  logic [63:0] ex_result64, rdata64;
  logic [4:0]  ex_dest;
  logic [1:0]  ex_ld_size;
  logic        data_ok, wb_allow_in, flush;

  logic        me_allow_in, wb_valid, wb_gr_we, me_fwd_busy;
  logic [31:0] wb_pc, wb_result, me_fwd_res;
  logic [4:0]  wb_dest, me_dest;

  logic        me_allow_in_w, wb_valid_w, wb_gr_we_w, me_fwd_busy_w;
  logic [31:0] wb_pc_w;
  logic [63:0] wb_result_w, me_fwd_res_w;
  logic [4:0]  wb_dest_w, me_dest_w;

  me_unit_varlat #(.DATA_W(32), .PC_W(32), .DEST_W(5), .DROP_W(2)) dut (
    .clk(clk), .resetn(resetn), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_result(ex_result64[31:0]), .ex_res_from_mem(ex_res_from_mem), .ex_gr_we(ex_gr_we),
    .ex_dest(ex_dest), .ex_ld_size(ex_ld_size), .ex_ld_unsigned(ex_ld_unsigned),
    .ex_req_sent(ex_req_sent), .me_allow_in(me_allow_in), .data_ok(data_ok),
    .rdata(rdata64[31:0]), .wb_allow_in(wb_allow_in), .flush(flush), .wb_valid(wb_valid),
    .wb_pc(wb_pc), .wb_gr_we(wb_gr_we), .wb_dest(wb_dest), .wb_result(wb_result),
    .me_dest(me_dest), .me_fwd_res(me_fwd_res), .me_fwd_busy(me_fwd_busy)
  );

  me_unit_varlat #(.DATA_W(64), .PC_W(32), .DEST_W(5), .DROP_W(2)) dut_w (
    .clk(clk), .resetn(resetn), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_result(ex_result64), .ex_res_from_mem(ex_res_from_mem), .ex_gr_we(ex_gr_we),
    .ex_dest(ex_dest), .ex_ld_size(ex_ld_size), .ex_ld_unsigned(ex_ld_unsigned),
    .ex_req_sent(ex_req_sent), .me_allow_in(me_allow_in_w), .data_ok(data_ok),
    .rdata(rdata64), .wb_allow_in(wb_allow_in), .flush(flush), .wb_valid(wb_valid_w),
    .wb_pc(wb_pc_w), .wb_gr_we(wb_gr_we_w), .wb_dest(wb_dest_w), .wb_result(wb_result_w),
    .me_dest(me_dest_w), .me_fwd_res(me_fwd_res_w), .me_fwd_busy(me_fwd_busy_w)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Model: one ME slot plus the queue of outstanding memory requests (1 = owner was flushed).
  bit          m_valid, m_have;
  ins_t        m_ins;
  logic [63:0] m_data;
  bit          memq[$];

  bit          pr_mine, pr_avail, pr_allow, e_wbv, e_busy, cmp_en;
  logic [63:0] e_res32, e_res64, e_fwd;
  logic [4:0]  e_dest;
  int          e_drop;

  function automatic logic [63:0] ext_model(input int dw, input logic [63:0] d,
                                            input logic [63:0] addr, input logic [1:0] size,
                                            input bit uns);
    int nb, n, off;
    logic [63:0] v, r;
    nb = dw / 8;
    n = 1 << size;
    if (n > nb) n = nb;
    off = int'(addr[2:0]) % nb;
    off = off - (off % n);
    v = d >> (8 * off);
    r = '0;
    for (int i = 0; i < 8 * n; i++) r[i] = v[i];
    if (!uns && v[8 * n - 1]) for (int i = 8 * n; i < dw; i++) r[i] = 1'b1;
    return r;
  endfunction

  task automatic predict();
    logic [63:0] d, x32, x64;
    pr_mine  = data_ok && memq.size() > 0 && !memq[0];
    pr_avail = m_have || !m_ins.req || pr_mine;
    pr_allow = !m_valid || (pr_avail && wb_allow_in);
    e_wbv    = m_valid && pr_avail && !flush;
    e_busy   = m_valid && m_ins.mem && !pr_avail;
    d        = m_have ? m_data : rdata64;
    x32      = ext_model(32, d, m_ins.res, m_ins.size, m_ins.uns);
    x64      = ext_model(64, d, m_ins.res, m_ins.size, m_ins.uns);
    e_res32  = m_ins.mem ? x32 : {32'h0, m_ins.res[31:0]};
    e_res64  = m_ins.mem ? x64 : m_ins.res;
    e_fwd    = m_ins.we ? e_res32 : 64'h0;
    e_dest   = (m_valid && m_ins.we) ? m_ins.dest : 5'h0;
    e_drop   = 0;
    foreach (memq[i]) if (memq[i]) e_drop++;
  endtask

  task automatic update();
    if (!resetn) begin
      m_valid = 0; m_have = 0; m_ins = '0; m_data = '0;
      memq.delete();
    end else begin
      if (data_ok && memq.size() > 0) void'(memq.pop_front());
      if (flush) begin
        if (m_valid && m_ins.req && !m_have && !pr_mine) foreach (memq[i]) memq[i] = 1'b1;
        m_valid = 0; m_have = 0;
      end else if (m_valid && pr_avail && wb_allow_in) begin
        m_valid = 0; m_have = 0;
      end else if (pr_mine && !wb_allow_in) begin
        m_have = 1; m_data = rdata64;
      end
      if (pr_allow && ex_valid && !flush) begin
        m_valid = 1;
        m_ins = '{pc: ex_pc, res: ex_result64, mem: ex_res_from_mem, we: ex_gr_we,
                  dest: ex_dest, size: ex_ld_size, uns: ex_ld_unsigned, req: ex_req_sent};
        if (ex_req_sent) memq.push_back(1'b0);
      end
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("wb_valid", 64'(wb_valid), 64'(e_wbv));
      chk("wb_valid_w", 64'(wb_valid_w), 64'(e_wbv));
      chk("me_allow_in", 64'(me_allow_in), 64'(pr_allow));
      chk("me_fwd_busy", 64'(me_fwd_busy), 64'(e_busy));
      chk("me_dest", 64'(me_dest), 64'(e_dest));
      chk("drop_cnt", 64'(dut.drop_cnt_q), 64'(e_drop));
      chk("buf_valid", 64'(dut.buf_valid_q), 64'(m_have));
      if (e_wbv) begin
        chk("wb_pc", 64'(wb_pc), 64'(m_ins.pc));
        chk("wb_gr_we", 64'(wb_gr_we), 64'(m_ins.we));
        chk("wb_dest", 64'(wb_dest), 64'(m_ins.dest));
        chk("wb_result", 64'(wb_result), e_res32);
        chk("wb_result_w", wb_result_w, e_res64);
      end
      if (m_valid && !e_busy) chk("me_fwd_res", 64'(me_fwd_res), e_fwd);
    end
  end

  task automatic idle_in();
    resetn = 1; ex_valid = 0; ex_req_sent = 0; ex_res_from_mem = 0; ex_gr_we = 0;
    ex_pc = '0; ex_result64 = '0; ex_dest = '0; ex_ld_size = '0; ex_ld_unsigned = 0;
    data_ok = 0; rdata64 = '0; wb_allow_in = 1; flush = 0;
  endtask

  task automatic put_ins(input logic [31:0] pc, input logic [63:0] res, input bit mem,
                         input bit we, input logic [4:0] dest, input logic [1:0] size,
                         input bit uns, input bit req);
    ex_valid = 1; ex_pc = pc; ex_result64 = res; ex_res_from_mem = mem; ex_gr_we = we;
    ex_dest = dest; ex_ld_size = size; ex_ld_unsigned = uns; ex_req_sent = req;
  endtask

  task automatic eval();
    predict();
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    update();
    #1;
  endtask

  task automatic resp(input logic [63:0] d, input bit allow);
    idle_in(); data_ok = 1; rdata64 = d; wb_allow_in = allow;
  endtask

  task automatic rand_cycle();
    int nfl, kind;
    nfl = 0;
    foreach (memq[i]) if (memq[i]) nfl++;
    idle_in();
    resetn = ($urandom_range(0, 299) != 0);
    if (resetn) begin
      data_ok     = (memq.size() > 0) && ($urandom_range(0, 2) == 0);
      wb_allow_in = ($urandom_range(0, 3) != 0);
      flush       = (nfl < 3) && ($urandom_range(0, 19) == 0);
    end
    rdata64 = {$urandom, $urandom};
    predict();
    if (resetn && !flush && $urandom_range(0, 2) != 0) begin
      kind = $urandom_range(0, 2);
      put_ins($urandom, {$urandom, $urandom}, kind == 0, kind != 1 && $urandom_range(0, 3) != 0,
              5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              kind != 2 && pr_allow);
    end
    eval();
    step();
  endtask

  initial begin
    cmp_en = 0;
    idle_in(); resetn = 0; eval(); step();
    cmp_en = 1;
    idle_in(); resetn = 0; eval(); step();

    idle_in(); eval();
    chk("rst wb_valid", 64'(wb_valid), 64'd0);
    chk("rst me_dest", 64'(me_dest), 64'd0);
    chk("rst fwd_busy", 64'(me_fwd_busy), 64'd0);
    chk("rst allow_in", 64'(me_allow_in), 64'd1);
    step();

    // Word load answered the cycle after capture.
    idle_in(); put_ins(32'h1c00_0010, 64'h1000, 1, 1, 5'd5, 2'd2, 0, 1); eval(); step();
    resp(64'h8765_4321, 1); eval();
    chk("word wb_valid", 64'(wb_valid), 64'd1);
    chk("word wb_result", 64'(wb_result), 64'h8765_4321);
    chk("word wb_result_w", wb_result_w, 64'hffff_ffff_8765_4321);
    chk("word fwd_busy", 64'(me_fwd_busy), 64'd0);
    step();

    // Response three cycles late.
    idle_in(); put_ins(32'h1c00_0014, 64'h1004, 1, 1, 5'd6, 2'd2, 1, 1); eval(); step();
    for (int k = 0; k < 3; k++) begin
      idle_in(); eval();
      chk("late fwd_busy", 64'(me_fwd_busy), 64'd1);
      chk("late allow_in", 64'(me_allow_in), 64'd0);
      chk("late wb_valid", 64'(wb_valid), 64'd0);
      step();
    end
    resp(64'h1234_5678, 1); eval();
    chk("late wb_valid on ok", 64'(wb_valid), 64'd1);
    step();

    // WB backpressure buffers the response.
    idle_in(); put_ins(32'h1c00_0018, 64'h1008, 1, 1, 5'd7, 2'd2, 0, 1); eval(); step();
    resp(64'h0000_00a5, 0); eval(); step();
    idle_in(); wb_allow_in = 0; rdata64 = 64'h5555_5555; eval();
    chk("bp buf_valid", 64'(dut.buf_valid_q), 64'd1);
    chk("bp wb_result held", 64'(wb_result), 64'ha5);
    step();
    idle_in(); put_ins(32'h1c00_0020, 64'h1234, 0, 1, 5'd8, 2'd0, 0, 0); eval();
    chk("bp release result", 64'(wb_result), 64'ha5);
    chk("bp release allow", 64'(me_allow_in), 64'd1);
    step();
    idle_in(); eval();
    chk("bp next pc", 64'(wb_pc), 64'h1c00_0020);
    chk("bp next result", 64'(wb_result), 64'h1234);
    step();

    // Flush while waiting, then a stale response is dropped.
    idle_in(); put_ins(32'h1c00_0030, 64'h2000, 1, 1, 5'd9, 2'd2, 0, 1); eval(); step();
    idle_in(); flush = 1; eval();
    chk("flush wb_valid", 64'(wb_valid), 64'd0);
    step();
    chk("flush drop_cnt", 64'(dut.drop_cnt_q), 64'd1);
    idle_in(); put_ins(32'h1c00_0034, 64'h2000, 1, 1, 5'd10, 2'd0, 0, 1); eval(); step();
    resp(64'hdead, 1); eval();
    chk("drop wb_valid", 64'(wb_valid), 64'd0);
    chk("drop fwd_busy", 64'(me_fwd_busy), 64'd1);
    step();
    resp(64'h0000_00f0, 1); eval();
    chk("drop byte result", 64'(wb_result), 64'hffff_fff0);
    step();

    // Extraction sweep.
    for (int sz = 0; sz < 4; sz++) begin
      for (int off = 0; off < 8; off++) begin
        for (int u = 0; u < 2; u++) begin
          idle_in();
          put_ins(32'h1c00_0100, 64'(32'h3000 + off), 1, 1, 5'd11, 2'(sz), 1'(u), 1);
          eval(); step();
          resp(64'h0123_4567_80ff_7f01, 1); eval();
          if (sz == 0 && off == 3 && u == 0) chk("byte3 s", 64'(wb_result), 64'hffff_ff80);
          if (sz == 1 && off == 2 && u == 1) chk("half2 u", 64'(wb_result), 64'h0000_80ff);
          if (sz == 3) chk("dword w", wb_result_w, 64'h0123_4567_80ff_7f01);
          step();
        end
      end
    end

    // Reset with an orphaned response outstanding and a load pending.
    idle_in(); put_ins(32'h1c00_0200, 64'h4000, 1, 1, 5'd12, 2'd2, 0, 1); eval(); step();
    idle_in(); flush = 1; eval(); step();
    idle_in(); put_ins(32'h1c00_0204, 64'h4004, 1, 1, 5'd13, 2'd2, 0, 1); eval(); step();
    idle_in(); resetn = 0; eval(); step();
    idle_in(); eval();
    chk("rst2 wb_valid", 64'(wb_valid), 64'd0);
    chk("rst2 allow_in", 64'(me_allow_in), 64'd1);
    chk("rst2 drop_cnt", 64'(dut.drop_cnt_q), 64'd0);
    chk("rst2 me_dest", 64'(me_dest), 64'd0);
    step();

    for (int c = 0; c < 4000; c++) rand_cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
